ddr3_ui_traffic_gen: RTL and testbench
======================================

Name: ddr3_ui_traffic_gen

Overview:
- Initiator side of the DDR3 controller's native user interface (UI), clocked by the UI clock.
- Once calibration completes and a start pulse arrives, it writes a block of patterned bursts, reads them back in order and compares every returned beat.
- Reports pass/fail and an error count.
- Serves as the board bring-up tester for the DDR3 stage.

Parameters:
- ADDR_WIDTH, 28, width of app_addr.
- DATA_WIDTH, 256, width of one UI data beat (one full burst per beat); must be a multiple of 32.
- BURST_COUNT, 16, bursts written and read per pass; power of two, 2..1024.
- ADDR_STEP, 8, app_addr increment per burst.
- BASE_ADDR, 0, app_addr of the first burst.

Ports:
- sys_clk  in  1  UI clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- init_calib_complete  in  1  controller calibration done (level).
- start  in  1  one-cycle pulse; begins a pass; ignored unless in IDLE.
- seed  in  32  pattern seed; sampled on an accepted start.
- app_addr  out  ADDR_WIDTH  command address.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when app_en&&app_rdy.
- app_wdf_data  out  DATA_WIDTH  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (one beat per burst).
- app_wdf_mask  out  DATA_WIDTH/8  always 0.
- app_wdf_rdy  in  1  data accepted when app_wdf_wren&&app_wdf_rdy.
- app_rd_data  in  DATA_WIDTH  read data.
- app_rd_data_valid  in  1  read beat valid.
- app_rd_data_end  in  1  ignored (one beat per burst).
- busy  out  1  pass in progress.
- done  out  1  pass complete; sticky until next accepted start.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  16  mismatching beats in the pass; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, app_addr=BASE_ADDR, state IDLE.
- Pattern for burst k:
  - word(k) = seed + k, mod 2^32.
  - The beat is word(k) replicated DATA_WIDTH/32 times.
  - Address of burst k = BASE_ADDR + k*ADDR_STEP, truncated to ADDR_WIDTH (wrap permitted).
- States:
  - IDLE: on start, go to WAIT_CAL. Latch seed, clear err_count/done/pass, busy=1.
  - WAIT_CAL: go to WRITE when init_calib_complete=1. Waits indefinitely otherwise.
  - WRITE:
    - Command path: wcmd_cnt counts accepted write commands; app_en=1, app_cmd=000 while wcmd_cnt<BURST_COUNT.
    - Data path: wdat_cnt counts accepted write beats; app_wdf_wren=1 while wdat_cnt<BURST_COUNT.
    - The two paths are independent, except data may lead a command by at most 1 burst; app_wdf_wren is held low when wdat_cnt>wcmd_cnt.
    - Each path holds addr/data stable until accepted.
    - Exit to READ when both counters reach BURST_COUNT.
  - READ:
    - rcmd_cnt counts accepted read commands; app_en=1, app_cmd=001 until BURST_COUNT are accepted.
    - rbeat_cnt counts app_rd_data_valid beats independently of rcmd_cnt; beats may arrive while commands are still issuing.
    - Each beat is compared against word(rbeat_cnt); a mismatch increments err_count, saturating.
    - Exit to DONE when rbeat_cnt==BURST_COUNT.
  - DONE: one cycle. Sets done=1, pass=(err_count==0), busy=0; then IDLE.
- app_en and app_wdf_wren are never asserted outside WRITE/READ.
- All outputs are registered; a handshake seen at cycle N advances addr/data at N+1.
- Simultaneous events:
  - Command accept and data accept in the same cycle both count.
  - start while busy is ignored.
- Read beats arriving outside READ (spurious) are ignored and not counted.
- init_calib_complete dropping mid-pass is ignored; the pass continues.
- Reset mid-pass: immediate return to IDLE with all outputs 0. In-flight reads are not drained; the next pass must start after the controller is reset too.
- Counter width: clog2(BURST_COUNT)+1 bits.

Decomposition:
- Package ddr3_tg_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001.
  - State enum {IDLE, WAIT_CAL, WRITE, READ, DONE}.
  - Function pattern_word(seed,k).
- One sub-module, ddr3_tg_pattern: combinational replicator from 32-bit word to DATA_WIDTH beat. Instantiated twice, once for write data and once for read compare.
- Everything else lives in the top FSM.

Test Plan:
- Controller model with app_rdy=app_wdf_rdy=1 and read latency 20; start with seed=32'h1000, BURST_COUNT=16:
  - Exactly 16 writes to addr 0,8,...,120 with word 0x1000..0x100F.
  - Then 16 reads.
  - done=1, pass=1, err_count=0.
- Random backpressure on app_rdy/app_wdf_rdy (50%): addr/data held stable while unaccepted, no duplicate or missing bursts, pass=1.
- Model corrupts read beat 3 and beat 15: err_count=2, pass=0, done sticky until next start.
- init_calib_complete low for 100 cycles after start: no app_en/app_wdf_wren during that time; the pass proceeds once it rises.
- Second start pulse during READ: ignored, counts unchanged. After done, new start with seed=32'hFFFFFFFF: words wrap 0xFFFFFFFF, 0x00000000, ..., pass=1.
- sys_rst asserted mid-WRITE: all outputs 0 asynchronously, state IDLE. A later start gives a clean full pass.

Source files
------------

// File: rtl/ddr3_tg_pkg.sv
// ddr3_tg_pkg: shared command codes, FSM states and pattern function for the DDR3 UI traffic generator.
package ddr3_tg_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DONE} tg_state_t;
    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] k);
        return seed + k;
    endfunction
endpackage

// File: rtl/ddr3_tg_pattern.sv
// ddr3_tg_pattern: replicates a 32-bit pattern word across a full UI data beat.
module ddr3_tg_pattern #(
    parameter int DATA_WIDTH = 256
) (
    input  logic [31:0]           word,
    output logic [DATA_WIDTH-1:0] beat
);
    assign beat = {(DATA_WIDTH/32){word}};
endmodule

// File: rtl/ddr3_ui_traffic_gen.sv
// ddr3_ui_traffic_gen: writes a block of patterned bursts over the DDR3 native UI, reads them back and counts mismatching beats.
module ddr3_ui_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter int ADDR_WIDTH  = 28,
    parameter int DATA_WIDTH  = 256,
    parameter int BURST_COUNT = 16,
    parameter int ADDR_STEP   = 8,
    parameter int BASE_ADDR   = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    init_calib_complete,
    input  logic                    start,
    input  logic [31:0]             seed,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    app_rd_data_end,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count
);
    localparam int CW = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0] BC = CW'(BURST_COUNT);

    tg_state_t state;
    logic [31:0] seed_q, wword, rword;
    logic [CW-1:0] wcmd_cnt, wdat_cnt, rcmd_cnt, rbeat_cnt, wc_n, wd_n, rc_n, rb_n;
    logic [DATA_WIDTH-1:0] exp_beat;
    logic cmd_acc, dat_acc, mismatch, unused;

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [CW-1:0] k);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(k) * ADDR_WIDTH'(ADDR_STEP);
    endfunction

    ddr3_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (.word(wword), .beat(app_wdf_data));
    ddr3_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pat (.word(rword), .beat(exp_beat));

    assign rword        = pattern_word(seed_q, 32'(rbeat_cnt));
    assign cmd_acc      = app_en && app_rdy;
    assign dat_acc      = app_wdf_wren && app_wdf_rdy;
    assign wc_n         = wcmd_cnt + CW'(cmd_acc);
    assign wd_n         = wdat_cnt + CW'(dat_acc);
    assign rc_n         = rcmd_cnt + CW'(cmd_acc);
    assign rb_n         = rbeat_cnt + CW'(app_rd_data_valid);
    assign mismatch     = app_rd_data != exp_beat;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign unused       = app_rd_data_end;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state        <= IDLE;
            seed_q       <= '0;
            wword        <= '0;
            wcmd_cnt     <= '0;
            wdat_cnt     <= '0;
            rcmd_cnt     <= '0;
            rbeat_cnt    <= '0;
            app_addr     <= burst_addr('0);
            app_cmd      <= CMD_WRITE;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= WAIT_CAL;
                    seed_q    <= seed;
                    wcmd_cnt  <= '0;
                    wdat_cnt  <= '0;
                    rcmd_cnt  <= '0;
                    rbeat_cnt <= '0;
                    err_count <= '0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    busy      <= 1'b1;
                end
                WAIT_CAL: if (init_calib_complete) begin
                    state        <= WRITE;
                    app_en       <= 1'b1;
                    app_cmd      <= CMD_WRITE;
                    app_addr     <= burst_addr('0);
                    app_wdf_wren <= 1'b1;
                    wword        <= seed_q;
                end
                WRITE: begin
                    wcmd_cnt <= wc_n;
                    wdat_cnt <= wd_n;
                    if (wc_n == BC && wd_n == BC) begin
                        state        <= READ;
                        app_en       <= 1'b1;
                        app_cmd      <= CMD_READ;
                        app_addr     <= burst_addr('0);
                        app_wdf_wren <= 1'b0;
                    end else begin
                        // data may run at most one burst ahead of its command
                        app_en       <= wc_n < BC;
                        app_addr     <= burst_addr(wc_n);
                        app_wdf_wren <= wd_n < BC && wd_n <= wc_n;
                        wword        <= pattern_word(seed_q, 32'(wd_n));
                    end
                end
                READ: begin
                    rcmd_cnt  <= rc_n;
                    rbeat_cnt <= rb_n;
                    app_addr  <= burst_addr(rc_n);
                    app_en    <= rc_n < BC && rb_n != BC;
                    err_count <= err_count + 16'(app_rd_data_valid && mismatch && err_count != 16'hFFFF);
                    if (rb_n == BC) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    pass  <= err_count == 16'd0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_ui_traffic_gen.sv
// tb_ddr3_ui_traffic_gen: directed bench with a UI controller model (latency 20) for ddr3_ui_traffic_gen.
module tb_ddr3_ui_traffic_gen;
    logic         clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         init_calib_complete = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  seed = '0;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy = 1'b0;
    logic [255:0] app_wdf_data;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b0;
    logic [31:0]  app_wdf_mask;
    logic [255:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;
    logic         busy, done, pass;
    logic [15:0]  err_count;

    int passed = 0, total = 0;

    ddr3_ui_traffic_gen dut (
        .sys_clk(clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .start(start), .seed(seed), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // controller model: handshakes decided and recorded on the falling edge
    logic         bp = 1'b0, corrupt = 1'b0, clr = 1'b0;
    logic [27:0]  wa[$], ra[$];
    logic [255:0] wd[$], rq_data[$];
    int           rq_due[$];
    int           cyc = 0, nbeat = 0, last_w = 0, first_r = 0, stab_err = 0;
    logic         p_en = 0, p_rdy = 0, p_wren = 0, p_wrdy = 0;
    logic [27:0]  p_addr;
    logic [2:0]   p_cmd;
    logic [255:0] p_data, rdd;

    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            wa.delete(); ra.delete(); wd.delete(); rq_data.delete(); rq_due.delete();
            nbeat = 0; last_w = 0; first_r = 0; stab_err = 0;
        end
        if (sys_rst) begin
            if (p_en && !p_rdy && (app_en !== 1'b1 || app_addr !== p_addr || app_cmd !== p_cmd)) stab_err++;
            if (p_wren && !p_wrdy && (app_wdf_wren !== 1'b1 || app_wdf_data !== p_data)) stab_err++;
            if (app_wdf_end !== app_wdf_wren || app_wdf_mask !== '0) stab_err++;
        end
        app_rdy     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        app_wdf_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (app_en && app_rdy) begin
            if (app_cmd == 3'b000) begin
                wa.push_back(app_addr);
                last_w = cyc;
            end else begin
                ra.push_back(app_addr);
                if (first_r == 0) first_r = cyc;
                rdd = '0;
                foreach (wa[i]) if (wa[i] == app_addr && i < wd.size()) rdd = wd[i];
                rq_data.push_back(rdd);
                rq_due.push_back(cyc + 20);
            end
        end
        if (app_wdf_wren && app_wdf_rdy) wd.push_back(app_wdf_data);
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            rdd = rq_data.pop_front();
            void'(rq_due.pop_front());
            if (corrupt && (nbeat == 3 || nbeat == 15)) rdd[0] = ~rdd[0];
            app_rd_data = rdd;
            app_rd_data_valid = 1'b1;
            nbeat++;
        end else begin
            app_rd_data = '0;
            app_rd_data_valid = 1'b0;
        end
        p_en = app_en; p_rdy = app_rdy; p_addr = app_addr; p_cmd = app_cmd;
        p_wren = app_wdf_wren; p_wrdy = app_wdf_rdy; p_data = app_wdf_data;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_model();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk); seed = s; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk("done_reached", done, 1'b1);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_stream(input logic [31:0] s);
        logic [31:0] w;
        chk("n_wr_cmd", wa.size(), 16);
        chk("n_wr_data", wd.size(), 16);
        chk("n_rd_cmd", ra.size(), 16);
        chk("n_rd_beat", nbeat, 16);
        chk("rd_after_wr", first_r > last_w, 1'b1);
        for (int k = 0; k < 16; k++) begin
            w = s + 32'(k);
            if (k < wa.size()) chk($sformatf("wr_addr[%0d]", k), wa[k], k * 8);
            if (k < wd.size()) chk($sformatf("wr_data[%0d]", k), wd[k], {8{w}});
            if (k < ra.size()) chk($sformatf("rd_addr[%0d]", k), ra[k], k * 8);
        end
    endtask

    initial begin
        logic seen;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_count, 16'd0);
        chk("rst_addr", app_addr, 28'd0);
        sys_rst = 1'b1;

        clear_model();
        pulse_start(32'h1000);
        chk("busy_after_start", busy, 1'b1);
        wait_done();
        chk("p1_pass", pass, 1'b1);
        chk("p1_err", err_count, 16'd0);
        check_stream(32'h1000);

        bp = 1'b1;
        clear_model();
        pulse_start(32'h2000);
        wait_done();
        bp = 1'b0;
        chk("bp_pass", pass, 1'b1);
        chk("bp_hold_stable", stab_err, 0);
        check_stream(32'h2000);

        corrupt = 1'b1;
        clear_model();
        pulse_start(32'h3000);
        wait_done();
        corrupt = 1'b0;
        chk("bad_err", err_count, 16'd2);
        chk("bad_pass", pass, 1'b0);
        repeat (10) @(negedge clk);
        chk("bad_done_sticky", done, 1'b1);
        chk("bad_pass_sticky", pass, 1'b0);

        init_calib_complete = 1'b0;
        clear_model();
        pulse_start(32'h4000);
        chk("cal_done_cleared", done, 1'b0);
        seen = 1'b0;
        repeat (100) begin @(negedge clk); seen |= app_en | app_wdf_wren; end
        chk("cal_no_traffic", seen, 1'b0);
        chk("cal_busy", busy, 1'b1);
        init_calib_complete = 1'b1;
        n = 0;
        while (!app_en && n < 50) begin @(negedge clk); n++; end
        chk("cal_write_begins", app_en, 1'b1);
        init_calib_complete = 1'b0;
        wait_done();
        init_calib_complete = 1'b1;
        chk("cal_pass", pass, 1'b1);
        check_stream(32'h4000);

        clear_model();
        pulse_start(32'h5000);
        n = 0;
        while (ra.size() < 2 && n < 200) begin @(negedge clk); n++; end
        chk("in_read", ra.size() >= 2, 1'b1);
        pulse_start(32'hDEAD);
        chk("busy_start_ignored", busy, 1'b1);
        wait_done();
        chk("ign_pass", pass, 1'b1);
        check_stream(32'h5000);

        clear_model();
        pulse_start(32'hFFFFFFFF);
        wait_done();
        chk("wrap_pass", pass, 1'b1);
        check_stream(32'hFFFFFFFF);

        clear_model();
        pulse_start(32'h7000);
        n = 0;
        while (wa.size() < 4 && n < 200) begin @(negedge clk); n++; end
        chk("mid_write", app_en && app_cmd == 3'b000, 1'b1);
        #2 sys_rst = 1'b0;
        #1;
        chk("arst_app_en", app_en, 1'b0);
        chk("arst_wren", app_wdf_wren, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", app_addr, 28'd0);
        chk("arst_data", app_wdf_data, 256'd0);
        chk("arst_err", err_count, 16'd0);
        repeat (3) @(negedge clk);
        sys_rst = 1'b1;
        clear_model();
        pulse_start(32'h8000);
        wait_done();
        chk("post_rst_pass", pass, 1'b1);
        chk("post_rst_err", err_count, 16'd0);
        check_stream(32'h8000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
